// File: rtl/counter_mod_k_ro_pkg.sv
// Shared width constant and count type for the mod-k roll-over counter.
package counter_mod_k_ro_pkg;
    localparam int CNT_W_DEF = 3;

    typedef logic [CNT_W_DEF-1:0] count_t;

    // Largest modulus an N-bit counter can serve (2^N-1).
    function automatic int max_k(input int w);
        return (1 << w) - 1;
    endfunction
endpackage

// File: rtl/counter_mod_k_ro_reg.sv
// N-bit count register: synchronous reset, clear-to-zero or increment.
module counter_mod_k_ro_reg #(
    parameter int N = 3
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_clr,
    output logic [N-1:0] o_count
);
    logic [N-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr)
            r_count <= '0;
        else
            r_count <= r_count + 1'b1;
    end

    assign o_count = r_count;
endmodule

// File: rtl/counter_mod_k_ro.sv
// Mod-k counter with registered roll-over pulse.
// Optional o_count port enabled by COUNTER_MOD_K_RO_COUNT_OUT_EN.
module counter_mod_k_ro
    import counter_mod_k_ro_pkg::*;
#(
    parameter int N = CNT_W_DEF
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [N-1:0] i_k,
    output logic         o_roll_over
`ifdef COUNTER_MOD_K_RO_COUNT_OUT_EN
    ,
    output logic [N-1:0] o_count
`endif
);
    logic [N-1:0] w_count;
    logic [N:0]   w_next;
    logic         w_k_zero;
    logic         w_wrap;
    logic         r_roll_over;

    // Compare count+1 >= k in N+1 bits so neither k-1 nor count+1 can wrap.
    assign w_next   = {1'b0, w_count} + 1'b1;
    assign w_k_zero = (i_k == '0);
    assign w_wrap   = !w_k_zero && (w_next >= {1'b0, i_k});

    counter_mod_k_ro_reg #(.N(N)) u_reg (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (w_wrap | w_k_zero),
        .o_count (w_count)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_roll_over <= 1'b0;
        else
            r_roll_over <= w_wrap;
    end

    assign o_roll_over = r_roll_over;
`ifdef COUNTER_MOD_K_RO_COUNT_OUT_EN
    assign o_count = w_count;
`endif
endmodule

// File: tb/tb_counter_mod_k_ro.sv
// Randomized bench for counter_mod_k_ro against a mod-k reference model.
module tb_counter_mod_k_ro;
    localparam int N = 3;

    logic         clk = 1'b0;
    logic         i_reset = 1'b1;
    logic [N-1:0] i_k = 3'd4;
    logic         o_roll_over;
    logic [N-1:0] o_count;

    int errors = 0;
    int checks = 0;

    counter_mod_k_ro #(.N(N)) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_k         (i_k),
        .o_roll_over (o_roll_over)
`ifdef COUNTER_MOD_K_RO_COUNT_OUT_EN
        ,
        .o_count     (o_count)
`endif
    );

`ifndef COUNTER_MOD_K_RO_COUNT_OUT_EN
    assign o_count = '0;
`endif

    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endfunction

    // Reference: position within the current period of k, plus the pulse.
    int m_cnt = 0;
    int m_ro  = 0;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        int k;
        k = int'(i_k);
        if (i_reset) begin
            m_cnt   <= 0;
            m_ro    <= 0;
            m_valid <= 1'b1;
        end else if (k == 0) begin
            m_cnt <= 0;
            m_ro  <= 0;
        end else if (m_cnt + 1 >= k) begin
            m_cnt <= 0;
            m_ro  <= 1;
        end else begin
            m_cnt <= m_cnt + 1;
            m_ro  <= 0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_ro", int'(o_roll_over), m_ro);
`ifdef COUNTER_MOD_K_RO_COUNT_OUT_EN
            chk("model_count", int'(o_count), m_cnt);
`endif
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        step(1);
        i_reset = 1'b0;
    endtask

    task automatic count_pulses(input int n, output int p);
        p = 0;
        repeat (n) begin
            step(1);
            if (o_roll_over) p++;
        end
    endtask

    initial begin
        int p;
        // reset state
        step(1);
        chk("reset_ro", int'(o_roll_over), 0);
`ifdef COUNTER_MOD_K_RO_COUNT_OUT_EN
        chk("reset_count", int'(o_count), 0);
`endif
        i_reset = 1'b0;

        // k=4: pulse on every 4th edge after release
        for (int i = 1; i <= 16; i++) begin
            step(1);
            chk($sformatf("k4_edge%0d", i), int'(o_roll_over), (i % 4 == 0) ? 1 : 0);
        end

        // k=1: pulse every cycle, count stays 0
        i_k = 3'd1;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            step(1);
            chk($sformatf("k1_edge%0d", i), int'(o_roll_over), 1);
`ifdef COUNTER_MOD_K_RO_COUNT_OUT_EN
            chk("k1_count", int'(o_count), 0);
`endif
        end

        // k=0: never a pulse
        i_k = 3'd0;
        do_reset();
        count_pulses(20, p);
        chk("k0_pulses", p, 0);

        // k=7 (max): first pulse on edge 7, three pulses in 21 edges
        i_k = 3'd7;
        do_reset();
        step(6);
        chk("k7_edge6", int'(o_roll_over), 0);
`ifdef COUNTER_MOD_K_RO_COUNT_OUT_EN
        chk("k7_count6", int'(o_count), 6);
`endif
        step(1);
        chk("k7_edge7", int'(o_roll_over), 1);
        count_pulses(21, p);
        chk("k7_pulses21", p, 3);

        // k=6 up to count 5, then k=3: wrap at the next edge
        i_k = 3'd6;
        do_reset();
        step(5);
        chk("k6_edge5_ro", int'(o_roll_over), 0);
        i_k = 3'd3;
        step(1);
        chk("k6to3_wrap", int'(o_roll_over), 1);
        step(2);
        chk("k3_mid", int'(o_roll_over), 0);
        step(1);
        chk("k3_period", int'(o_roll_over), 1);

        // k=4, reset at count=2, pulse 4 edges after release
        i_k = 3'd4;
        do_reset();
        step(2);
        do_reset();
        chk("midreset_ro", int'(o_roll_over), 0);
`ifdef COUNTER_MOD_K_RO_COUNT_OUT_EN
        chk("midreset_count", int'(o_count), 0);
`endif
        step(3);
        chk("midreset_edge3", int'(o_roll_over), 0);
        step(1);
        chk("midreset_edge4", int'(o_roll_over), 1);

        // random k changes and resets, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) i_k = N'($urandom_range(0, 7));
            i_reset = ($urandom_range(0, 40) == 0);
            step(1);
        end
        i_reset = 1'b0;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
